tile_seq_ctrl: RTL
==================

Name: tile_seq_ctrl

Overview:
Parametrised top-level tile sequencer for the systolic datapath. On one start it runs NUM_TILES load passes, one per row tile. It then runs one layering pass and reports done. Each pass uses a start-pulse / busy handshake with the valid and layering sub-controllers. Adds what the fixed top controller lacks: a tile index and last-tile flag, an abort input, and an acknowledge timeout with a sticky error.

Parameters:
NUM_TILES, 2, number of row-tile load passes per run (N/4); must be >= 1
TILE_W, 3, width of tile_idx; 2^TILE_W >= NUM_TILES
TIMEOUT, 16, max cycles to wait for sub-controller busy to rise after a start pulse; 0 disables the timeout
TO_W, 8, width of the timeout counter; 2^TO_W > TIMEOUT

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  begin a run; sampled only in IDLE
abort  in  1  cancel the run in progress; return to IDLE next cycle
load_busy  in  1  busy from the valid pipeline controller
layer_busy  in  1  busy from the layering pipeline controller
start_load  out  1  one-cycle pulse; starts a load pass
start_layer  out  1  one-cycle pulse; starts the layering pass
mode  out  3  0 idle, 1 load, 2 layer (drives the weight controller)
tile_idx  out  TILE_W  index of the tile currently loading
last_tile  out  1  tile_idx == NUM_TILES-1
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on successful completion
err  out  1  sticky timeout flag

Behaviour:
- Reset (rst_n low, async): state IDLE, tile_idx 0, timeout counter 0, err 0. All outputs 0, except last_tile, which is 1 when NUM_TILES==1.
- Outputs are Moore decodes of the registered state, plus tile_idx and err registers; no input-to-output combinational path.
- States: IDLE, ISSUE_LOAD, WAIT_LOAD_ON, WAIT_LOAD_OFF, ADV_TILE, ISSUE_LAYER, WAIT_LAY_ON, WAIT_LAY_OFF, DONE, ERR.
- IDLE:
  - start=1 and abort=0 -> ISSUE_LOAD.
  - On that edge tile_idx <= 0 and err <= 0.
- ISSUE_LOAD: start_load=1 -> WAIT_LOAD_ON. The timeout counter clears on this edge.
- WAIT_LOAD_ON:
  - load_busy=1 -> WAIT_LOAD_OFF.
  - Otherwise the counter increments.
  - TIMEOUT != 0 and the counter reaches TIMEOUT with load_busy still 0 -> ERR.
- WAIT_LOAD_OFF: load_busy=0 -> ISSUE_LAYER if last_tile, else ADV_TILE. No timeout in this state.
- ADV_TILE: tile_idx <= tile_idx+1 -> ISSUE_LOAD.
- ISSUE_LAYER: start_layer=1 -> WAIT_LAY_ON. The counter clears.
- WAIT_LAY_ON: same as WAIT_LOAD_ON, but uses layer_busy and leads to WAIT_LAY_OFF.
- WAIT_LAY_OFF: layer_busy=0 -> DONE.
- DONE: done=1 -> IDLE.
- ERR: err <= 1 (held until the next accepted start) -> IDLE. done is not asserted.
- mode:
  - 1 in ISSUE_LOAD, WAIT_LOAD_ON, WAIT_LOAD_OFF and ADV_TILE.
  - 2 in ISSUE_LAYER, WAIT_LAY_ON and WAIT_LAY_OFF.
  - 0 in all other states.
- Latency: start sampled at edge k gives start_load high in cycle k+1.
- tile_idx holds its final value after DONE, ERR or abort until the next accepted start.
- Abort:
  - In any state except IDLE, DONE or ERR, abort=1 -> IDLE on the next edge.
  - No done pulse, err unchanged.
  - Abort overrides every other transition in that cycle, including a busy edge.
- Simultaneous events:
  - abort and start together in IDLE: stay IDLE.
  - start while busy=1: ignored, not queued.
- Sub-controller busy already high when the FSM enters WAIT_*_ON: advance on the next edge, which is legal.
- NUM_TILES==1: ADV_TILE is never entered; last_tile is constantly 1.
- tile_idx never wraps within a run; the maximum value is NUM_TILES-1.

Test Plan:
1. NUM_TILES=2. Pulse start; the model raises load_busy 2 cycles after each start_load for 3 cycles, and layer_busy similarly.
   -> start_load pulses twice with tile_idx 0 then 1; last_tile=1 on the second; start_layer pulses once; done pulses once; busy falls the cycle after done.
2. TIMEOUT=4, load_busy held 0 after start.
   -> 4 cycles in WAIT_LOAD_ON, then ERR; err=1 sticky; done never asserted; busy=0. The next start clears err.
3. Abort during WAIT_LOAD_OFF on tile 1.
   -> IDLE on the next edge; mode=0, busy=0, no done, tile_idx stays 1.
4. start and abort both high in IDLE -> no start_load, busy stays 0. A start pulse mid-run -> ignored; exactly one done.
5. rst_n driven low mid-WAIT_LAY_OFF (asynchronous, between edges).
   -> all outputs 0 immediately; tile_idx=0, err=0.
6. NUM_TILES=1, layer_busy high already on entry to WAIT_LAY_ON.
   -> no ADV_TILE; sequence runs ISSUE_LOAD ... ISSUE_LAYER, WAIT_LAY_ON (one cycle), WAIT_LAY_OFF, then done.

Source files
------------

// File: rtl/tile_seq_ctrl.sv
// Tile sequencer: runs NUM_TILES load passes then one layering pass per start,
// with abort, per-tile index/last flag and a busy-acknowledge timeout (sticky err).
module tile_seq_ctrl #(
  parameter int NUM_TILES = 2,
  parameter int TILE_W    = 3,
  parameter int TIMEOUT   = 16,
  parameter int TO_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              load_busy,
  input  logic              layer_busy,
  output logic              start_load,
  output logic              start_layer,
  output logic [2:0]        mode,
  output logic [TILE_W-1:0] tile_idx,
  output logic              last_tile,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [3:0] S_IDLE        = 4'd0;
  localparam logic [3:0] S_ISSUE_LOAD  = 4'd1;
  localparam logic [3:0] S_WAIT_LOAD_ON  = 4'd2;
  localparam logic [3:0] S_WAIT_LOAD_OFF = 4'd3;
  localparam logic [3:0] S_ADV_TILE    = 4'd4;
  localparam logic [3:0] S_ISSUE_LAYER = 4'd5;
  localparam logic [3:0] S_WAIT_LAY_ON  = 4'd6;
  localparam logic [3:0] S_WAIT_LAY_OFF = 4'd7;
  localparam logic [3:0] S_DONE        = 4'd8;
  localparam logic [3:0] S_ERR         = 4'd9;

  localparam logic [TILE_W-1:0] LAST_IDX = TILE_W'(NUM_TILES - 1);
  localparam bit                TO_EN    = (TIMEOUT != 0);
  // Counter value seen in the final allowed wait cycle; unused when the timeout is off.
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  logic [3:0]        state_q, state_d;
  logic [TILE_W-1:0] tile_q, tile_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              last_w;
  logic              abortable;

  assign last_w    = (tile_q == LAST_IDX);
  assign abortable = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);

  always_comb begin
    state_d = state_q;
    tile_d  = tile_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_ISSUE_LOAD;
          tile_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_ISSUE_LOAD: begin
        state_d = S_WAIT_LOAD_ON;
        cnt_d   = '0;
      end
      S_WAIT_LOAD_ON: begin
        if (load_busy) begin
          state_d = S_WAIT_LOAD_OFF;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
          if (TO_EN && (cnt_q == TO_LAST)) state_d = S_ERR;
        end
      end
      S_WAIT_LOAD_OFF: begin
        if (!load_busy) state_d = last_w ? S_ISSUE_LAYER : S_ADV_TILE;
      end
      S_ADV_TILE: begin
        tile_d  = tile_q + TILE_W'(1);
        state_d = S_ISSUE_LOAD;
      end
      S_ISSUE_LAYER: begin
        state_d = S_WAIT_LAY_ON;
        cnt_d   = '0;
      end
      S_WAIT_LAY_ON: begin
        if (layer_busy) begin
          state_d = S_WAIT_LAY_OFF;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
          if (TO_EN && (cnt_q == TO_LAST)) state_d = S_ERR;
        end
      end
      S_WAIT_LAY_OFF: begin
        if (!layer_busy) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      S_ERR: begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over any busy edge or tile advance in the same cycle.
    if (abort && abortable) begin
      state_d = S_IDLE;
      tile_d  = tile_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tile_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tile_q  <= tile_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign start_load  = (state_q == S_ISSUE_LOAD);
  assign start_layer = (state_q == S_ISSUE_LAYER);
  assign done        = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign tile_idx    = tile_q;
  assign last_tile   = last_w;
  assign err         = err_q;

  always_comb begin
    mode = 3'd0;
    if ((state_q == S_ISSUE_LOAD) || (state_q == S_WAIT_LOAD_ON) ||
        (state_q == S_WAIT_LOAD_OFF) || (state_q == S_ADV_TILE))
      mode = 3'd1;
    else if ((state_q == S_ISSUE_LAYER) || (state_q == S_WAIT_LAY_ON) ||
             (state_q == S_WAIT_LAY_OFF))
      mode = 3'd2;
  end

endmodule
